// File: rtl/counter_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : counter_pkg
//  Description : Shared BCD constants and the per-nibble clamp helper used by
//                the BCD down counter and its decade sub-module.
//  Revision    : 1.0  initial release
// ============================================================================
package counter_pkg;

    localparam logic [3:0] BCD_MAX  = 4'd9;
    localparam logic [3:0] BCD_ZERO = 4'd0;

    // Any nibble above 9 (A..F) becomes 9, so a bad load value can never
    // push a digit out of the BCD range.
    function automatic logic [3:0] bcd_clamp(input logic [3:0] nib);
        return (nib > BCD_MAX) ? BCD_MAX : nib;
    endfunction

endpackage : counter_pkg
`default_nettype wire

// File: rtl/bcd_down_digit.sv
`default_nettype none
// ============================================================================
//  Module      : bcd_down_digit
//  Description : One MOD-10 decade that counts down. It decrements on a borrow
//                and wraps from 0 to 9. A load takes priority over the borrow.
//  Ports       : clk        system clock
//                rst        asynchronous active-high reset (q -> 0)
//                load       synchronous load of clamp(d)
//                d[3:0]     load nibble (A..F are clamped to 9)
//                borrow_in  decrement request for this decade
//                q[3:0]     current digit
//                is_zero    high when q == 0
//  Revision    : 1.0  initial release
// ============================================================================
module bcd_down_digit
    import counter_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic [3:0] d,
    input  logic       borrow_in,
    output logic [3:0] q,
    output logic       is_zero
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= BCD_ZERO;
        end else if (load) begin
            q <= bcd_clamp(d);
        end else if (borrow_in) begin
            q <= (q == BCD_ZERO) ? BCD_MAX : (q - 4'd1);
        end
    end

    assign is_zero = (q == BCD_ZERO);

endmodule : bcd_down_digit
`default_nettype wire

// File: rtl/bcd_down_counter.sv
`default_nettype none
// ============================================================================
//  Module      : bcd_down_counter
//  Description : Cascadable multi-digit BCD down counter with load, enable,
//                wrap / one-shot stop mode and a borrow output for chaining.
//  Ports       : clk         system clock
//                rst         asynchronous active-high reset
//                en          count enable
//                load        synchronous load of d (priority over en)
//                d           load value, BCD, digit 0 in [3:0]
//                one_shot    0 = wrap 0..0 -> 9..9, 1 = stop at 0..0
//                q           current count, BCD, digit 0 in [3:0]
//                zero        all digits of q are 0
//                borrow_out  en & zero & ~done (enable of next instance)
//                done        sticky one-shot completion flag
//  Revision    : 1.0  initial release
// ============================================================================
module bcd_down_counter
    import counter_pkg::*;
#(
    parameter int DIGITS = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   d,
    input  logic                  one_shot,
    output logic [4*DIGITS-1:0]   q,
    output logic                  zero,
    output logic                  borrow_out,
    output logic                  done
);

    logic [DIGITS-1:0] digit_zero;
    logic [DIGITS-1:0] borrow_in;
    // lower_zero[k] is high when every digit below k is zero; the top entry
    // therefore covers the whole count.
    logic [DIGITS:0]   lower_zero;
    logic              count_ok;

    // In one-shot mode a count of 0..0 freezes: no digit may borrow.
    assign count_ok      = en & ~(one_shot & zero);
    assign lower_zero[0] = 1'b1;
    assign zero          = lower_zero[DIGITS];
    assign borrow_out    = en & zero & ~done;

    generate
        for (genvar k = 0; k < DIGITS; k++) begin : g_digit
            assign lower_zero[k+1] = lower_zero[k] & digit_zero[k];
            assign borrow_in[k]    = count_ok & lower_zero[k];

            bcd_down_digit u_digit (
                .clk       (clk),
                .rst       (rst),
                .load      (load),
                .d         (d[4*k +: 4]),
                .borrow_in (borrow_in[k]),
                .q         (q[4*k +: 4]),
                .is_zero   (digit_zero[k])
            );
        end
    endgenerate

    // done only sets in one-shot mode and is cleared solely by load or rst;
    // switching back to wrap mode leaves it set.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            done <= 1'b0;
        end else if (load) begin
            done <= 1'b0;
        end else if (en & zero & one_shot) begin
            done <= 1'b1;
        end
    end

endmodule : bcd_down_counter
`default_nettype wire

// File: doc/bcd_down_counter.md
Name: bcd_down_counter

Overview:
- Synchronous, cascadable multi-digit BCD (MOD-10 per digit) down counter.
- It is the counting-down counterpart of the team's MOD-10 up counter.
- Used for countdown timers, delay generation and digit-display decrementing.
- Loadable start value, count enable, wrap or one-shot stop mode, and a borrow output for chaining further instances.

Parameters:
- DIGITS, 2, number of BCD decades (1..8); the count width is 4*DIGITS bits.

Ports:
- clk  input  1  single system clock; all state updates on posedge clk.
- rst  input  1  asynchronous, active-high reset.
- en  input  1  count enable; decrement by one on a clock edge when high.
- load  input  1  synchronous load of d; priority over en.
- d  input  4*DIGITS  load value, BCD, digit 0 in bits [3:0].
- one_shot  input  1  0 = wrap 0..0 to 9..9; 1 = stop at 0..0.
- q  output  4*DIGITS  current count, BCD, digit 0 in bits [3:0].
- zero  output  1  combinational; high when every digit of q is 0.
- borrow_out  output  1  combinational; en & zero & ~done; feeds en of the next, more-significant instance.
- done  output  1  registered sticky flag, one-shot mode only.

Behaviour:
- Reset (rst=1, asynchronous, immediate): q=0, done=0. Consequently zero=1 and borrow_out=0 while en=0. Reset overrides load and en at any point, including mid-count.
- Priority per posedge: rst > load > en > hold.
- load=1:
  - q<=d and done<=0, regardless of en or one_shot.
  - A nibble of d in A..F is loaded as 9 (clamped per digit). Digits are clamped independently.
- en=1, load=0, zero=0:
  - Digit 0 decrements.
  - Digit k (k>0) decrements only when digits 0..k-1 are all 0. The internal borrow chain is combinational in the same cycle.
  - A digit at 0 that receives a borrow becomes 9.
  - Latency is 1 cycle: the value is visible in q on the edge after en is sampled.
- en=1, load=0, zero=1, one_shot=0:
  - All digits wrap to 9 (q becomes 9..9).
  - borrow_out=1 during that cycle, a one-cycle pulse per wrap while en is held.
- en=1, load=0, zero=1, one_shot=1:
  - q holds at 0.
  - done<=1 on that edge; done stays 1 until load or rst.
  - borrow_out=0 once done=1 (borrow_out = en & zero & ~done). This gives exactly one borrow pulse per one-shot countdown.
- en=0, load=0: q and done hold.
- Changing one_shot from 1 to 0 while done=1 and zero=1:
  - done is not cleared.
  - The next en edge wraps to 9..9, because done only gates borrow_out, not wrapping, in wrap mode. done remains set until load or rst.
- q never leaves valid BCD (0..9 per digit) under any input sequence.
- Cascading: instance B's en is driven from A.borrow_out. Both instances share clk and rst. B decrements on the same edge A wraps.

Decomposition:
- Shared package (counter_pkg): the BCD_MAX constant (4'd9), BCD_ZERO (4'd0), and a bcd_clamp function mapping any nibble to 0..9 (A..F to 9).
- One natural sub-module: bcd_down_digit, a single decade with these ports:
  - Inputs: clk, rst, load, d[3:0], borrow_in.
  - Outputs: q[3:0], is_zero.
- The top generates DIGITS instances:
  - borrow_in of digit k = en & (all digits below k zero).
  - The top holds done and the one-shot stop gating. The stop gating suppresses borrow_in of all digits when one_shot & zero.

Test Plan:
- Reset and hold: DIGITS=2; assert rst mid-count at q=37 -> q=00, done=0, zero=1 immediately (before the next edge); en=0 for 5 cycles -> q stays 00.
- Wrap count: load 05, one_shot=0, en=1 for 7 cycles -> q sequence 04,03,02,01,00,99,98; borrow_out=1 only in the cycle q=00 with en=1.
- Decade borrow: load 40, en=1 for 1 cycle -> q=39; load 100 in DIGITS=3 then one en edge -> q=099.
- One-shot: load 03, one_shot=1, en=1 for 6 cycles -> q=02,01,00,00,00,00; done rises on the edge after q=00 is first sampled with en=1; borrow_out high for exactly one cycle; then load 12 -> done=0, q=12.
- Load priority and clamp: load=1 and en=1 together with d=8'hA7 -> q=97 (not 96); d=8'hFF -> q=99.
- Cascade: two DIGITS=1 instances, B.en=A.borrow_out, both loaded with 0 and 2 (tens=2), en=1 for 21 cycles -> combined count 20 down to 00, then 99; B changes only on A's wrap edges.
